// File: rtl/i2s_frame_scheduler.sv
// Sequencing controller for a 16-bit stereo I2S encoder: generates BCLK and the encoder reset,
// buffers upstream L/R samples and updates the parallel data only inside the encoder latch window.
module i2s_frame_scheduler #(
  parameter int unsigned DIV           = 2,
  parameter bit          UNDERRUN_MUTE = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [15:0] i_data_l,
  input  logic [15:0] i_data_r,
  output logic        o_bclk,
  output logic        o_enc_rst_x,
  output logic [15:0] o_data_l,
  output logic [15:0] o_data_r,
  output logic        o_frame,
  output logic        o_running,
  output logic [15:0] o_underrun_cnt
);

  localparam int unsigned PhMax = 2 * DIV - 1;
  localparam int unsigned PhW   = $clog2(2 * DIV);

  typedef enum logic [1:0] {StIdle, StPrime, StRun, StStop} state_e;

  state_e         state_q;
  logic [PhW-1:0] phase_q;
  logic [PhW-1:0] phase_nxt;
  logic [5:0]     slot_q;
  logic [31:0]    fifo_q [2];
  logic           wr_ptr_q;
  logic           rd_ptr_q;
  logic [1:0]     cnt_q;
  logic [31:0]    head;
  logic           active;
  logic           fall_evt;
  logic           upd_evt;
  logic           wrap_evt;
  logic           fifo_empty;
  logic           push;
  logic           pop;

  assign active     = (state_q == StRun) || (state_q == StStop);
  assign fall_evt   = active && (phase_q == PhW'(PhMax));
  assign phase_nxt  = fall_evt ? '0 : phase_q + PhW'(1);
  // Slot 55 -> 56 opens the encoder latch window; 63 -> 0 starts a new frame.
  assign upd_evt    = fall_evt && (slot_q == 6'd55);
  assign wrap_evt   = fall_evt && (slot_q == 6'd63);
  assign fifo_empty = (cnt_q == 2'd0);
  assign head       = fifo_q[rd_ptr_q];
  assign o_ready    = !i_rst && (cnt_q != 2'd2);
  assign push       = i_valid && o_ready;
  assign pop        = !fifo_empty && ((state_q == StPrime) || upd_evt);
  assign o_running  = active;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= StIdle;
      phase_q        <= '0;
      slot_q         <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      cnt_q          <= 2'd0;
      o_bclk         <= 1'b0;
      o_enc_rst_x    <= 1'b0;
      o_data_l       <= '0;
      o_data_r       <= '0;
      o_frame        <= 1'b0;
      o_underrun_cnt <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= {i_data_l, i_data_r};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q   <= cnt_q + {1'b0, push} - {1'b0, pop};
      o_frame <= wrap_evt;

      case (state_q)
        StIdle: begin
          phase_q     <= '0;
          slot_q      <= '0;
          o_bclk      <= 1'b0;
          o_enc_rst_x <= 1'b0;
          o_data_l    <= '0;
          o_data_r    <= '0;
          if (i_enable && !fifo_empty) begin
            state_q <= StPrime;
          end
        end
        StPrime: begin
          // Encoder leaves reset with this sample already on its inputs.
          {o_data_l, o_data_r} <= head;
          o_enc_rst_x          <= 1'b1;
          o_bclk               <= 1'b0;
          phase_q              <= '0;
          slot_q               <= '0;
          state_q              <= StRun;
        end
        StRun, StStop: begin
          phase_q <= phase_nxt;
          o_bclk  <= (phase_nxt >= PhW'(DIV));
          if (fall_evt) begin
            slot_q <= slot_q + 6'd1;
          end
          if (upd_evt) begin
            if (!fifo_empty) begin
              {o_data_l, o_data_r} <= head;
            end else begin
              if (UNDERRUN_MUTE) begin
                o_data_l <= '0;
                o_data_r <= '0;
              end
              if (o_underrun_cnt != 16'hFFFF) begin
                o_underrun_cnt <= o_underrun_cnt + 16'd1;
              end
            end
          end
          if (state_q == StRun) begin
            if (!i_enable) begin
              state_q <= StStop;
            end
          end else if (i_enable) begin
            state_q <= StRun;
          end else if (wrap_evt) begin
            state_q     <= StIdle;
            phase_q     <= '0;
            o_bclk      <= 1'b0;
            o_enc_rst_x <= 1'b0;
            o_data_l    <= '0;
            o_data_r    <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
